// File: rtl/i2s_defines.sv
// Shared constants and types for the I2S/TDM transmitter.
package i2s_defines;

  localparam int unsigned DEFAULT_DIV_WIDTH = 16;
  localparam int unsigned UCNT_WIDTH        = 16;

  typedef enum logic {
    MODE_I2S = 1'b0,
    MODE_LJ  = 1'b1
  } mode_e;

endpackage

// File: rtl/i2s_clock_gen.sv
// BCLK and MCLK dividers; each half period lasts div+1 clk cycles.
module i2s_clock_gen
  import i2s_defines::*;
#(
  parameter int unsigned DIV_WIDTH = DEFAULT_DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] bclk_div,
  input  logic [DIV_WIDTH-1:0] mclk_div,
  output logic                 i2s_clock,
  output logic                 i2s_mclock,
  output logic                 bclk_fall_c
);

  logic [DIV_WIDTH-1:0] bclk_cnt;
  logic [DIV_WIDTH-1:0] mclk_cnt;
  logic                 bclk_tc_c;
  logic                 mclk_tc_c;

  // >= so a divider lowered below the running count still terminates at once
  assign bclk_tc_c   = (bclk_cnt >= bclk_div);
  assign mclk_tc_c   = (mclk_cnt >= mclk_div);
  assign bclk_fall_c = enable && bclk_tc_c && i2s_clock;

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      bclk_cnt   <= '0;
      mclk_cnt   <= '0;
      i2s_clock  <= 1'b0;
      i2s_mclock <= 1'b0;
    end else begin
      if (bclk_tc_c) begin
        bclk_cnt  <= '0;
        i2s_clock <= ~i2s_clock;
      end else begin
        bclk_cnt <= bclk_cnt + DIV_WIDTH'(1);
      end
      if (mclk_tc_c) begin
        mclk_cnt   <= '0;
        i2s_mclock <= ~i2s_mclock;
      end else begin
        mclk_cnt <= mclk_cnt + DIV_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/i2s_tdm_transmitter.sv
// I2S / left-justified TDM transmitter: frame counter, holding and shift
// registers, I2S delay flop and underrun accounting.
module i2s_tdm_transmitter
  import i2s_defines::*;
#(
  parameter int unsigned SAMPLE_WIDTH = 24,
  parameter int unsigned SLOT_WIDTH   = 32,
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned DIV_WIDTH    = DEFAULT_DIV_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        mode,
  input  logic [DIV_WIDTH-1:0]        bclk_div,
  input  logic [DIV_WIDTH-1:0]        mclk_div,
  input  logic [SAMPLE_WIDTH-1:0]     sample_data,
  input  logic                        sample_valid,
  output logic                        sample_ready,
  output logic [$clog2(CHANNELS)-1:0] sample_channel,
  output logic                        starved,
  output logic [UCNT_WIDTH-1:0]       underrun_count,
  output logic                        i2s_mclock,
  output logic                        i2s_clock,
  output logic                        i2s_lr,
  output logic                        i2s_data
);

  localparam int unsigned CH_W  = $clog2(CHANNELS);
  localparam int unsigned BIT_W = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;
  localparam int unsigned PAD   = SLOT_WIDTH - SAMPLE_WIDTH;

  logic                    bclk_fall_c;
  logic                    running;
  logic [BIT_W-1:0]        bit_idx;
  logic [CH_W-1:0]         slot_idx;
  logic [SAMPLE_WIDTH-1:0] holding;
  logic                    holding_full;
  logic [SLOT_WIDTH-1:0]   shift;
  mode_e                   mode_q;

  logic [BIT_W-1:0]        bit_next_c;
  logic [CH_W-1:0]         slot_next_c;
  logic                    load_c;
  logic                    frame_start_c;
  logic                    accept_c;
  logic [SLOT_WIDTH-1:0]   shift_next_c;
  mode_e                   mode_now_c;
  logic [CH_W-1:0]         channel_next_c;

  i2s_clock_gen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_clock_gen (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .bclk_div    (bclk_div),
    .mclk_div    (mclk_div),
    .i2s_clock   (i2s_clock),
    .i2s_mclock  (i2s_mclock),
    .bclk_fall_c (bclk_fall_c)
  );

  assign sample_ready = enable && !rst && !holding_full;
  assign accept_c     = sample_valid && sample_ready;

  // Position the next fall strobe moves to; the first strobe after start-up is frame bit 0
  always_comb begin
    bit_next_c  = '0;
    slot_next_c = '0;
    if (running) begin
      if (bit_idx == BIT_W'(SLOT_WIDTH - 1)) begin
        bit_next_c  = '0;
        slot_next_c = (slot_idx == CH_W'(CHANNELS - 1)) ? '0 : slot_idx + CH_W'(1);
      end else begin
        bit_next_c  = bit_idx + BIT_W'(1);
        slot_next_c = slot_idx;
      end
    end
  end

  assign load_c        = bclk_fall_c && (bit_next_c == '0);
  assign frame_start_c = load_c && (slot_next_c == '0);
  assign mode_now_c    = frame_start_c ? mode_e'(mode) : mode_q;
  assign channel_next_c = (sample_channel == CH_W'(CHANNELS - 1)) ? '0
                                                                 : sample_channel + CH_W'(1);

  always_comb begin
    shift_next_c = shift << 1;
    if (load_c) begin
      shift_next_c = holding_full ? (SLOT_WIDTH'(holding) << PAD) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      running        <= 1'b0;
      bit_idx        <= '0;
      slot_idx       <= '0;
      holding        <= '0;
      holding_full   <= 1'b0;
      shift          <= '0;
      mode_q         <= MODE_I2S;
      sample_channel <= '0;
      starved        <= 1'b0;
      i2s_lr         <= 1'b0;
      i2s_data       <= 1'b0;
      if (rst) begin
        underrun_count <= '0;
      end
    end else begin
      if (accept_c) begin
        holding      <= sample_data;
        holding_full <= 1'b1;
      end
      if (bclk_fall_c) begin
        running  <= 1'b1;
        bit_idx  <= bit_next_c;
        slot_idx <= slot_next_c;
        shift    <= shift_next_c;
        mode_q   <= mode_now_c;
        // I2S replays the bit that was on the pin during the previous BCLK
        i2s_data <= (mode_now_c == MODE_LJ) ? shift_next_c[SLOT_WIDTH-1] : shift[SLOT_WIDTH-1];
        if (load_c) begin
          i2s_lr         <= (slot_next_c >= CH_W'(CHANNELS / 2));
          sample_channel <= channel_next_c;
          if (holding_full) begin
            holding_full <= 1'b0;
            starved      <= 1'b0;
          end else begin
            starved <= 1'b1;
            if (underrun_count != '1) begin
              underrun_count <= underrun_count + UCNT_WIDTH'(1);
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tdm_transmitter.sv
// Bench for i2s_tdm_transmitter: a 2-channel and a 4-channel instance checked
// every cycle against a cycle-count based model plus literal pin expectations.
module tb_i2s_tdm_transmitter;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        mode;
  logic [15:0] bclk_div;
  logic [15:0] mclk_div;
  logic [23:0] data0, data1;
  logic        valid0, valid1;

  logic        ready0, ready1;
  logic        chan0;
  logic [1:0]  chan1;
  logic        starved0, starved1;
  logic [15:0] ucnt0, ucnt1;
  logic        mclk0, mclk1, bclk0, bclk1, lr0, lr1, dout0, dout1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  i2s_tdm_transmitter #(.SAMPLE_WIDTH(24), .SLOT_WIDTH(32), .CHANNELS(2), .DIV_WIDTH(16)) u_dut2 (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .bclk_div(bclk_div), .mclk_div(mclk_div),
    .sample_data(data0), .sample_valid(valid0), .sample_ready(ready0), .sample_channel(chan0),
    .starved(starved0), .underrun_count(ucnt0), .i2s_mclock(mclk0), .i2s_clock(bclk0),
    .i2s_lr(lr0), .i2s_data(dout0));

  i2s_tdm_transmitter #(.SAMPLE_WIDTH(24), .SLOT_WIDTH(32), .CHANNELS(4), .DIV_WIDTH(16)) u_dut4 (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .bclk_div(bclk_div), .mclk_div(mclk_div),
    .sample_data(data1), .sample_valid(valid1), .sample_ready(ready1), .sample_channel(chan1),
    .starved(starved1), .underrun_count(ucnt1), .i2s_mclock(mclk1), .i2s_clock(bclk1),
    .i2s_lr(lr1), .i2s_data(dout1));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: everything is derived from k, the number of enabled clk edges.
  int          m_k[2];
  bit          m_full[2];
  logic [23:0] m_hold[2];
  logic [23:0] m_cur[2];
  bit          m_starved[2];
  int          m_ucnt[2];
  int          m_chan[2];
  bit          m_lr[2], m_data[2], m_ljprev[2], m_bclk[2], m_mclk[2];

  task automatic model_step(input int i, input int ch, input bit v, input logic [23:0] d);
    bit acc;
    int n, fb, slot, b;
    bit lj;
    if (rst) m_ucnt[i] = 0;
    if (rst || !enable) begin
      m_k[i] = 0; m_full[i] = 0; m_hold[i] = '0; m_cur[i] = '0; m_starved[i] = 0;
      m_chan[i] = 0; m_lr[i] = 0; m_data[i] = 0; m_ljprev[i] = 0; m_bclk[i] = 0; m_mclk[i] = 0;
      return;
    end
    acc = v && !m_full[i];
    m_k[i]++;
    m_bclk[i] = ((m_k[i] / (int'(bclk_div) + 1)) % 2) == 1;
    m_mclk[i] = ((m_k[i] / (int'(mclk_div) + 1)) % 2) == 1;
    if (m_k[i] % (2 * (int'(bclk_div) + 1)) == 0) begin
      n    = m_k[i] / (2 * (int'(bclk_div) + 1));
      fb   = (n - 1) % (ch * 32);
      slot = fb / 32;
      b    = fb % 32;
      if (b == 0) begin
        if (m_full[i]) begin
          m_cur[i] = m_hold[i]; m_full[i] = 0; m_starved[i] = 0;
        end else begin
          m_cur[i] = '0; m_starved[i] = 1;
          if (m_ucnt[i] < 16'hFFFF) m_ucnt[i]++;
        end
        m_chan[i] = (m_chan[i] + 1) % ch;
      end
      lj = (b < 24) ? m_cur[i][23 - b] : 1'b0;
      m_data[i]   = mode ? lj : m_ljprev[i];
      m_ljprev[i] = lj;
      m_lr[i]     = (slot >= ch / 2);
    end
    if (acc) begin
      m_hold[i] = d; m_full[i] = 1;
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    model_step(0, 2, valid0, data0);
    model_step(1, 4, valid1, data1);
  end

  task automatic check_inst(input int i, input string p, input bit rdy, input int ch, input bit stv,
                            input int uc, input bit mc, input bit bc, input bit lr, input bit dt);
    chk({p, "_ready"}, rdy, !rst && enable && !m_full[i]);
    chk({p, "_chan"}, ch, m_chan[i]);
    chk({p, "_starved"}, stv, m_starved[i]);
    chk({p, "_ucnt"}, uc, m_ucnt[i]);
    chk({p, "_mclk"}, mc, m_mclk[i]);
    chk({p, "_bclk"}, bc, m_bclk[i]);
    chk({p, "_lr"}, lr, m_lr[i]);
    chk({p, "_data"}, dt, m_data[i]);
  endtask

  // Per-cycle compare plus capture of pin bits at each BCLK falling edge
  bit q_data0[$], q_lr0[$], q_data1[$], q_lr1[$];
  int q_t0[$];
  bit pb0 = 0, pb1 = 0;

  always @(negedge clk) begin
    check_inst(0, "ch2", ready0, int'(chan0), starved0, int'(ucnt0), mclk0, bclk0, lr0, dout0);
    check_inst(1, "ch4", ready1, int'(chan1), starved1, int'(ucnt1), mclk1, bclk1, lr1, dout1);
    if (pb0 && !bclk0) begin q_data0.push_back(dout0); q_lr0.push_back(lr0); q_t0.push_back(cyc); end
    if (pb1 && !bclk1) begin q_data1.push_back(dout1); q_lr1.push_back(lr1); end
    pb0 = bclk0;
    pb1 = bclk1;
  end

  function automatic logic [31:0] qword(input int i, input bit lr, input int base);
    logic [31:0] w = '0;
    for (int b = 0; b < 32; b++) begin
      if (i == 0) w = {w[30:0], lr ? q_lr0[base + b] : q_data0[base + b]};
      else        w = {w[30:0], lr ? q_lr1[base + b] : q_data1[base + b]};
    end
    return w;
  endfunction

  function automatic int qsize(input int i);
    return (i == 0) ? q_data0.size() : q_data1.size();
  endfunction

  task automatic clear_q();
    q_data0.delete(); q_lr0.delete(); q_t0.delete(); q_data1.delete(); q_lr1.delete();
  endtask

  task automatic wait_falls(input int i, input int n);
    int t = 0;
    while (qsize(i) < n && t < 20000) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("wait_falls", qsize(i) >= n, 1'b1);
  endtask

  task automatic push(input int i, input logic [23:0] d, output int ch);
    int t = 0;
    bit r = 0;
    ch = -1;
    if (i == 0) begin valid0 = 1'b1; data0 = d; end
    else        begin valid1 = 1'b1; data1 = d; end
    while (!r && t < 5000) begin
      @(negedge clk);
      r  = (i == 0) ? ready0 : ready1;
      ch = (i == 0) ? int'(chan0) : int'(chan1);
      @(posedge clk);
      t++;
    end
    #1;
    if (i == 0) valid0 = 1'b0; else valid1 = 1'b0;
    chk("push_accept", r, 1'b1);
  endtask

  task automatic do_reset();
    enable = 1'b0;
    rst    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic frame_test(input bit lj, input logic [31:0] w0, input logic [31:0] w1);
    int ch;
    do_reset();
    mode = lj; bclk_div = 16'd1; mclk_div = 16'd1;
    clear_q();
    enable = 1'b1;
    push(0, 24'hA5A5A5, ch);
    push(0, 24'h5A5A5A, ch);
    wait_falls(0, 64);
    chk(lj ? "lj_word0" : "i2s_word0", qword(0, 0, 0), w0);
    chk(lj ? "lj_word1" : "i2s_word1", qword(0, 0, 32), w1);
    chk("lr_slot0", qword(0, 1, 0), 32'h0);
    chk("lr_slot1", qword(0, 1, 32), 32'hFFFF_FFFF);
    chk("bit_period", q_t0[1] - q_t0[0], 4);
    enable = 1'b0;
  endtask

  initial begin
    int ch;
    int c, first_b, first_m, second_b, second_m;
    bit pbb, pmm;
    rst = 1'b1; enable = 1'b0; mode = 1'b0; bclk_div = 16'd1; mclk_div = 16'd1;
    valid0 = 1'b0; valid1 = 1'b0; data0 = '0; data1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", ready0, 1'b0);
    chk("rst_ucnt", ucnt0, 16'd0);
    chk("rst_pins", {mclk0, bclk0, lr0, dout0, starved0}, 5'b0);
    @(posedge clk);
    #1;

    frame_test(1'b1, 32'hA5A5_A500, 32'h5A5A_5A00);
    frame_test(1'b0, 32'h52D2_D280, 32'h2D2D_2D00);

    // underrun in slot 1, recovery at the next slot start
    do_reset();
    mode = 1'b1; bclk_div = 16'd1;
    clear_q();
    enable = 1'b1;
    push(0, 24'hA5A5A5, ch);
    wait_falls(0, 33);
    chk("under_starved", starved0, 1'b1);
    chk("under_ucnt", ucnt0, 16'd1);
    push(0, 24'h923456, ch);
    wait_falls(0, 65);
    chk("under_slot1_zero", qword(0, 0, 32), 32'h0);
    chk("under_recover_bit", q_data0[64], 1'b1);
    chk("under_starved_clr", starved0, 1'b0);
    chk("under_ucnt_hold", ucnt0, 16'd1);
    enable = 1'b0;

    // four-slot TDM frame
    do_reset();
    mode = 1'b1; bclk_div = 16'd0;
    clear_q();
    enable = 1'b1;
    for (int s = 0; s < 4; s++) begin
      push(1, 24'(s + 1), ch);
      chk("tdm_chan", ch, s);
    end
    wait_falls(1, 97);
    chk("tdm_chan_wrap", chan1, 2'd0);
    wait_falls(1, 129);
    for (int s = 0; s < 4; s++) begin
      chk("tdm_word", qword(1, 0, 32 * s), 32'((s + 1) << 8));
      chk("tdm_lr", qword(1, 1, 32 * s), (s < 2) ? 32'h0 : 32'hFFFF_FFFF);
    end
    chk("tdm_frame_len", q_lr1[128], 1'b0);
    enable = 1'b0;

    // divider periods and first-toggle latency
    do_reset();
    bclk_div = 16'd0; mclk_div = 16'd3;
    enable = 1'b1;
    c = 0; first_b = -1; first_m = -1; second_b = -1; second_m = -1; pbb = 0; pmm = 0;
    while (c < 40 && second_m < 0) begin
      @(posedge clk);
      #1;
      c++;
      if (bclk0 && !pbb) begin if (first_b < 0) first_b = c; else if (second_b < 0) second_b = c; end
      if (mclk0 && !pmm) begin if (first_m < 0) first_m = c; else if (second_m < 0) second_m = c; end
      pbb = bclk0;
      pmm = mclk0;
    end
    chk("bclk_first", first_b, 1);
    chk("mclk_first", first_m, 4);
    chk("bclk_period", second_b - first_b, 2);
    chk("mclk_period", second_m - first_m, 8);
    enable = 1'b0;

    // reset at bit 10 of slot 1
    do_reset();
    mode = 1'b1; bclk_div = 16'd1; mclk_div = 16'd1;
    clear_q();
    enable = 1'b1;
    push(0, 24'hA5A5A5, ch);
    push(0, 24'h5A5A5A, ch);
    wait_falls(0, 43);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", ready0, 1'b0);
    @(posedge clk);
    #1;
    chk("midrst_pins", {mclk0, bclk0, lr0, dout0, starved0, chan0}, 6'b0);
    chk("midrst_ucnt", ucnt0, 16'd0);
    rst = 1'b0;
    clear_q();
    push(0, 24'h800001, ch);
    chk("midrst_chan", ch, 0);
    wait_falls(0, 24);
    chk("midrst_bit0", q_data0[0], 1'b1);
    chk("midrst_bit1", q_data0[1], 1'b0);
    chk("midrst_bit23", q_data0[23], 1'b1);
    enable = 1'b0;
    repeat (4) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
